// File: rtl/vector_write_back_controller.sv
// Vector register file write-back initiator.
// Buffers completed vector results in a small in-order FIFO, issues each one
// to the VRF as a single-cycle write, waits for the VRF to report completion,
// then retires the entry. Pending-destination flags let decode stall on RAW
// hazards against writes that are still queued.
module vector_write_back_controller #(
    parameter int LEN          = 32,
    parameter int VECTOR_SIZE  = 8,
    parameter int LENGTH_WIDTH = 4,
    parameter int DEPTH        = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4:0]                  in_rd,
    input  logic [VECTOR_SIZE*LEN-1:0]  in_data,
    input  logic [LENGTH_WIDTH-1:0]     in_length,
    output logic [1:0]                  rf_signal,
    output logic                        write_back_enabled,
    output logic [4:0]                  rf_rd,
    output logic [VECTOR_SIZE*LEN-1:0]  rf_data,
    output logic [LENGTH_WIDTH-1:0]     rf_length,
    input  logic [1:0]                  rf_status,
    input  logic [4:0]                  query_rs1,
    input  logic [4:0]                  query_rs2,
    output logic                        rs1_pending,
    output logic                        rs2_pending,
    output logic [$clog2(DEPTH):0]      queue_count,
    output logic                        idle
);

    // VRF command / status encodings shared with the register file.
    localparam logic [1:0] VECTOR_RF_NOP   = 2'b00;
    localparam logic [1:0] VECTOR_RF_WRITE = 2'b01;
    localparam logic [1:0] RF_NOP          = 2'b00;
    localparam logic [1:0] RF_FINISHED     = 2'b01;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]           DEPTH_C = CW'(DEPTH);
    localparam logic [LENGTH_WIDTH-1:0] VSIZE_L = LENGTH_WIDTH'(VECTOR_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [4:0]                 rd_mem   [DEPTH];
    logic [VECTOR_SIZE*LEN-1:0] data_mem [DEPTH];
    logic [LENGTH_WIDTH-1:0]    len_mem  [DEPTH];

    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           count;
    logic                    push, pop, issue;
    logic [LENGTH_WIDTH-1:0] len_clamped;
    logic [PW-1:0]           offset;

    assign in_ready    = (count < DEPTH_C);
    assign push        = in_valid & in_ready & rdy_in & ~rst;
    assign len_clamped = (in_length > VSIZE_L) ? VSIZE_L : in_length;
    assign queue_count = count;
    assign idle        = (count == '0) && (state == IDLE);

    // Next-state decode: zero-length heads retire straight from IDLE.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    if (len_mem[rd_ptr] == '0) begin
                        pop = rdy_in;
                    end else begin
                        issue      = rdy_in;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (rf_status == RF_FINISHED) begin
                    pop        = rdy_in;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, pointers, count and registered VRF request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            write_back_enabled <= 1'b0;
            rf_signal          <= VECTOR_RF_NOP;
            rf_rd              <= '0;
            rf_data            <= '0;
            rf_length          <= '0;
        end else if (rdy_in) begin
            state              <= state_next;
            write_back_enabled <= issue;
            rf_signal          <= issue ? VECTOR_RF_WRITE : VECTOR_RF_NOP;
            if (issue) begin
                rf_rd     <= rd_mem[rd_ptr];
                rf_data   <= data_mem[rd_ptr];
                rf_length <= len_mem[rd_ptr];
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= in_rd;
            data_mem[wr_ptr] <= in_data;
            len_mem[wr_ptr]  <= len_clamped;
        end
    end

    // RAW hazard check against every occupied, non-empty-length entry.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        offset      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr;
            if (({1'b0, offset} < count) && (len_mem[i] != '0)) begin
                if (rd_mem[i] == query_rs1) rs1_pending = 1'b1;
                if (rd_mem[i] == query_rs2) rs2_pending = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_write_back_controller.sv
// Directed self-checking bench for vector_write_back_controller.
module tb_vector_write_back_controller;

    localparam int LEN = 32;
    localparam int VS  = 8;
    localparam int LW  = 4;
    localparam int DEP = 2;

    localparam logic [1:0] VECTOR_RF_NOP   = 2'b00;
    localparam logic [1:0] VECTOR_RF_WRITE = 2'b01;
    localparam logic [1:0] RF_NOP          = 2'b00;
    localparam logic [1:0] RF_FINISHED     = 2'b01;

    logic              clk = 1'b0;
    logic              rst, rdy_in, in_valid, in_ready;
    logic [4:0]        in_rd, rf_rd, query_rs1, query_rs2;
    logic [VS*LEN-1:0] in_data, rf_data, pat;
    logic [LW-1:0]     in_length, rf_length;
    logic [1:0]        rf_signal, rf_status;
    logic              write_back_enabled, rs1_pending, rs2_pending, idle;
    logic [$clog2(DEP):0] queue_count;

    int n_checks = 0;
    int n_fail   = 0;

    vector_write_back_controller #(.LEN(LEN), .VECTOR_SIZE(VS), .LENGTH_WIDTH(LW), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_data(in_data), .in_length(in_length),
        .rf_signal(rf_signal), .write_back_enabled(write_back_enabled),
        .rf_rd(rf_rd), .rf_data(rf_data), .rf_length(rf_length),
        .rf_status(rf_status), .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .queue_count(queue_count), .idle(idle)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [4:0] rd, input logic [LW-1:0] len, input logic [VS*LEN-1:0] d);
        in_valid  = 1'b1;
        in_rd     = rd;
        in_length = len;
        in_data   = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy_in = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        in_length = '0; rf_status = RF_NOP; query_rs1 = '0; query_rs2 = '0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (write_back_enabled !== 1'b0) begin n_fail++; $display("FAIL reset_wbe got %b want 0", write_back_enabled); end
        n_checks++; if (rf_signal !== VECTOR_RF_NOP) begin n_fail++; $display("FAIL reset_rf_signal got %b want %b", rf_signal, VECTOR_RF_NOP); end
        n_checks++; if (queue_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", queue_count); end
        n_checks++; if ({rf_rd, rf_length} !== '0 || rf_data !== '0) begin n_fail++; $display("FAIL reset_rf_fields got rd=%0d len=%0d want 0", rf_rd, rf_length); end
        n_checks++; if ({rs1_pending, rs2_pending} !== 2'b00) begin n_fail++; $display("FAIL reset_pending got %b want 00", {rs1_pending, rs2_pending}); end
    endtask

    task automatic test_single();
        for (int i = 0; i < VS * LEN / 8; i++) pat[i*8 +: 8] = 8'(i + 1);
        drive_push(5'd5, 4'd8, pat);
        tick(); in_valid = 1'b0;
        n_checks++; if (queue_count !== 2'd1 || write_back_enabled !== 1'b0) begin n_fail++; $display("FAIL single_push got cnt=%0d wbe=%b want 1/0", queue_count, write_back_enabled); end
        tick();
        n_checks++; if (write_back_enabled !== 1'b1 || rf_signal !== VECTOR_RF_WRITE) begin n_fail++; $display("FAIL single_issue got wbe=%b sig=%b want 1/%b", write_back_enabled, rf_signal, VECTOR_RF_WRITE); end
        n_checks++; if (rf_rd !== 5'd5 || rf_length !== 4'd8 || rf_data !== pat) begin n_fail++; $display("FAIL single_fields got rd=%0d len=%0d data=%h want 5/8/%h", rf_rd, rf_length, rf_data, pat); end
        rf_status = RF_FINISHED;
        tick();
        n_checks++; if (write_back_enabled !== 1'b0 || rf_signal !== VECTOR_RF_NOP || rf_rd !== 5'd5) begin n_fail++; $display("FAIL single_wait got wbe=%b sig=%b rd=%0d want 0/00/5", write_back_enabled, rf_signal, rf_rd); end
        n_checks++; if (queue_count !== 2'd1 || idle !== 1'b0) begin n_fail++; $display("FAIL single_wait_cnt got cnt=%0d idle=%b want 1/0", queue_count, idle); end
        tick();
        rf_status = RF_NOP;
        n_checks++; if (queue_count !== 2'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL single_pop got cnt=%0d idle=%b want 0/1", queue_count, idle); end
    endtask

    task automatic test_fill();
        rf_status = RF_NOP;
        drive_push(5'd3, 4'd4, {VS{32'h3333_0003}});
        tick();
        drive_push(5'd7, 4'd2, {VS{32'h7777_0007}});
        tick();
        n_checks++; if (queue_count !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got cnt=%0d rdy=%b want 2/0", queue_count, in_ready); end
        n_checks++; if (write_back_enabled !== 1'b1 || rf_rd !== 5'd3) begin n_fail++; $display("FAIL fill_first_issue got wbe=%b rd=%0d want 1/3", write_back_enabled, rf_rd); end
        drive_push(5'd11, 4'd1, '0);
        tick(); tick();
        n_checks++; if (queue_count !== 2'd2) begin n_fail++; $display("FAIL fill_reject got cnt=%0d want 2", queue_count); end
        in_valid = 1'b0; rf_status = RF_FINISHED;
        tick();
        rf_status = RF_NOP;
        n_checks++; if (queue_count !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_release got cnt=%0d rdy=%b want 1/1", queue_count, in_ready); end
        tick();
        n_checks++; if (write_back_enabled !== 1'b1 || rf_rd !== 5'd7 || rf_length !== 4'd2) begin n_fail++; $display("FAIL fill_second_issue got wbe=%b rd=%0d len=%0d want 1/7/2", write_back_enabled, rf_rd, rf_length); end
        tick(); rf_status = RF_FINISHED;
        tick(); rf_status = RF_NOP;
        tick();
        n_checks++; if (queue_count !== 2'd0 || idle !== 1'b1 || rf_rd !== 5'd7) begin n_fail++; $display("FAIL fill_drain got cnt=%0d idle=%b rd=%0d want 0/1/7", queue_count, idle, rf_rd); end
    endtask

    task automatic test_zero_length();
        query_rs1 = 5'd9;
        drive_push(5'd9, 4'd0, '1);
        tick(); in_valid = 1'b0;
        n_checks++; if (queue_count !== 2'd1 || rs1_pending !== 1'b0 || write_back_enabled !== 1'b0) begin n_fail++; $display("FAIL zero_queued got cnt=%0d pend=%b wbe=%b want 1/0/0", queue_count, rs1_pending, write_back_enabled); end
        tick();
        n_checks++; if (queue_count !== 2'd0 || idle !== 1'b1 || write_back_enabled !== 1'b0 || rs1_pending !== 1'b0) begin n_fail++; $display("FAIL zero_pop got cnt=%0d idle=%b wbe=%b pend=%b want 0/1/0/0", queue_count, idle, write_back_enabled, rs1_pending); end
    endtask

    task automatic test_hazard();
        query_rs1 = 5'd12; query_rs2 = 5'd13;
        drive_push(5'd12, 4'd4, '0);
        tick(); in_valid = 1'b0;
        n_checks++; if ({rs1_pending, rs2_pending} !== 2'b10) begin n_fail++; $display("FAIL hazard_queued got %b want 10", {rs1_pending, rs2_pending}); end
        tick();
        n_checks++; if ({rs1_pending, rs2_pending} !== 2'b10) begin n_fail++; $display("FAIL hazard_issue got %b want 10", {rs1_pending, rs2_pending}); end
        tick(); rf_status = RF_FINISHED;
        n_checks++; if ({rs1_pending, rs2_pending} !== 2'b10) begin n_fail++; $display("FAIL hazard_wait got %b want 10", {rs1_pending, rs2_pending}); end
        tick(); rf_status = RF_NOP;
        n_checks++; if ({rs1_pending, rs2_pending} !== 2'b00 || queue_count !== 2'd0) begin n_fail++; $display("FAIL hazard_pop got %b cnt=%0d want 00/0", {rs1_pending, rs2_pending}, queue_count); end
    endtask

    task automatic test_rdy_drop();
        drive_push(5'd20, 4'd3, '0);
        tick(); in_valid = 1'b0;
        tick(); tick();
        rdy_in = 1'b0; rf_status = RF_FINISHED;
        drive_push(5'd21, 4'd1, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (queue_count !== 2'd1 || idle !== 1'b0 || rf_rd !== 5'd20) begin n_fail++; $display("FAIL rdy_hold[%0d] got cnt=%0d idle=%b rd=%0d want 1/0/20", k, queue_count, idle, rf_rd); end
        end
        in_valid = 1'b0; rdy_in = 1'b1;
        tick(); rf_status = RF_NOP;
        n_checks++; if (queue_count !== 2'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL rdy_resume got cnt=%0d idle=%b want 0/1", queue_count, idle); end
    endtask

    task automatic test_push_pop();
        drive_push(5'd9, 4'd0, '0);
        tick();
        drive_push(5'd10, 4'd1, '0);
        tick(); in_valid = 1'b0;
        n_checks++; if (queue_count !== 2'd1) begin n_fail++; $display("FAIL pushpop_count got cnt=%0d want 1", queue_count); end
        tick();
        n_checks++; if (write_back_enabled !== 1'b1 || rf_rd !== 5'd10) begin n_fail++; $display("FAIL pushpop_issue got wbe=%b rd=%0d want 1/10", write_back_enabled, rf_rd); end
        tick(); rf_status = RF_FINISHED;
        tick(); rf_status = RF_NOP;
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL pushpop_drain got idle=%b want 1", idle); end
    endtask

    task automatic test_reset_in_wait();
        rf_status = RF_NOP;
        drive_push(5'd1, 4'd1, '0);
        tick();
        drive_push(5'd2, 4'd1, '0);
        tick(); in_valid = 1'b0;
        tick();
        n_checks++; if (queue_count !== 2'd2) begin n_fail++; $display("FAIL rstwait_pre got cnt=%0d want 2", queue_count); end
        rst = 1'b1;
        tick(); rst = 1'b0;
        n_checks++; if (queue_count !== 2'd0 || idle !== 1'b1 || write_back_enabled !== 1'b0 || rf_rd !== 5'd0) begin n_fail++; $display("FAIL rstwait_clear got cnt=%0d idle=%b wbe=%b rd=%0d want 0/1/0/0", queue_count, idle, write_back_enabled, rf_rd); end
        drive_push(5'd4, 4'd15, {VS{32'hCAFE_0004}});
        tick(); in_valid = 1'b0;
        tick();
        n_checks++; if (write_back_enabled !== 1'b1 || rf_rd !== 5'd4 || rf_length !== 4'd8) begin n_fail++; $display("FAIL clamp_issue got wbe=%b rd=%0d len=%0d want 1/4/8", write_back_enabled, rf_rd, rf_length); end
        tick(); rf_status = RF_FINISHED;
        tick(); rf_status = RF_NOP;
        n_checks++; if (queue_count !== 2'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL clamp_drain got cnt=%0d idle=%b want 0/1", queue_count, idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_zero_length();
        test_hazard();
        test_rdy_drop();
        test_push_pop();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
